// File: rtl/trace_dump.sv
`default_nettype none
// ============================================================================
//  Module   : trace_dump
//  Purpose  : Unrolls one channel of the 512-entry circular capture RAM,
//             oldest sample first, and hands each sample to the UART one byte
//             at a time over a trmt/tx_done handshake. When the dump ends,
//             normally or by abort, it pulses clr_capture_done.
//  Revision : 1.0  initial release
// ============================================================================
module trace_dump #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dump_req,
    input  logic [1:0]          dump_ch,
    input  logic                dump_abort,
    input  logic                capture_done,
    input  logic [ADDR_W-1:0]   trace_end,
    input  logic [4*DATA_W-1:0] rdata,
    input  logic                tx_done,
    output logic                ram_en,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W-1:0]   tx_data,
    output logic                trmt,
    output logic                clr_capture_done,
    output logic                dump_busy,
    output logic                dump_err
);

    localparam logic [2:0] c_S_IDLE = 3'd0;
    localparam logic [2:0] c_S_RD   = 3'd1;
    localparam logic [2:0] c_S_RDW  = 3'd2;
    localparam logic [2:0] c_S_SEND = 3'd3;
    localparam logic [2:0] c_S_TXW  = 3'd4;
    localparam logic [2:0] c_S_FIN  = 3'd5;

    // Count value held while the final (oldest-to-newest last) byte is in flight.
    localparam logic [ADDR_W:0] c_LAST_CNT = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [1:0]      c_RD_LAT   = 2'(RD_LAT);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [1:0]        r_ch;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic [1:0]        r_lat;
    logic              r_dump_err;

    logic              w_accept;
    logic              w_abort;
    logic              w_data_valid;
    logic [DATA_W-1:0] w_rdata_sel;

    assign w_accept     = (r_state == c_S_IDLE) && dump_req && capture_done;
    // Abort only matters while a dump is in progress; FIN already finishes it.
    assign w_abort      = dump_abort && (r_state != c_S_IDLE) && (r_state != c_S_FIN);
    assign w_data_valid = (r_state == c_S_RDW) && (r_lat == c_RD_LAT);
    assign w_rdata_sel  = rdata[r_ch*DATA_W +: DATA_W];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; an abort overrides every other transition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (w_accept)     w_state_nxt = c_S_RD;
            c_S_RD:                     w_state_nxt = c_S_RDW;
            c_S_RDW:  if (w_data_valid) w_state_nxt = c_S_SEND;
            c_S_SEND:                   w_state_nxt = c_S_TXW;
            c_S_TXW:  if (tx_done)      w_state_nxt = (r_cnt == c_LAST_CNT) ? c_S_FIN : c_S_RD;
            c_S_FIN:                    w_state_nxt = c_S_IDLE;
            default:                    w_state_nxt = c_S_IDLE;
        endcase
        if (w_abort) begin
            w_state_nxt = c_S_FIN;
        end
    end

    // Datapath: dump context, read-latency counter, byte latch, progress counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ch       <= 2'd0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_tx_data  <= '0;
            r_lat      <= 2'd0;
            r_dump_err <= 1'b0;
        end else begin
            r_dump_err <= (r_state == c_S_IDLE) && dump_req && !capture_done;
            if (w_accept) begin
                r_ch     <= dump_ch;
                r_rd_ptr <= trace_end + 1'b1;
                r_cnt    <= '0;
            end
            // r_lat reads 1 in the first wait cycle, so data is taken when it equals RD_LAT.
            if (r_state == c_S_RD) begin
                r_lat <= 2'd1;
            end else if ((r_state == c_S_RDW) && (r_lat != c_RD_LAT)) begin
                r_lat <= r_lat + 2'd1;
            end
            if (w_data_valid && !w_abort) begin
                r_tx_data <= w_rdata_sel;
            end
            // Abort wins over a coincident tx_done: the byte is not counted.
            if ((r_state == c_S_TXW) && tx_done && !w_abort) begin
                r_cnt    <= r_cnt + 1'b1;
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign ram_en           = (r_state == c_S_RD);
    assign ram_addr         = ram_en ? r_rd_ptr : '0;
    assign tx_data          = r_tx_data;
    assign trmt             = (r_state == c_S_SEND) && !dump_abort;
    assign clr_capture_done = (r_state == c_S_FIN);
    assign dump_busy        = (r_state != c_S_IDLE);
    assign dump_err         = r_dump_err;

endmodule
`default_nettype wire

// File: tb/tb_trace_dump.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trace_dump
//  Purpose  : Directed self-checking bench for trace_dump. One instance uses
//             a 1-cycle RAM, a second a 2-cycle RAM for the latency test.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trace_dump;

    logic        clk = 1'b0;
    logic        rst;
    logic        capture_done;

    // Instance 1 (RD_LAT = 1)
    logic        dump_req1, dump_abort1, tx_done1, auto_tx, man_tx, auto_en;
    logic [1:0]  dump_ch1;
    logic [8:0]  trace_end1;
    logic [31:0] rdata1;
    logic        ram_en1, trmt1, clr1, busy1, err1;
    logic [8:0]  ram_addr1;
    logic [7:0]  tx_data1;

    // Instance 2 (RD_LAT = 2)
    logic        dump_req2, dump_abort2, tx_done2;
    logic [1:0]  dump_ch2;
    logic [8:0]  trace_end2;
    logic [31:0] rdata2, pipe2;
    logic        ram_en2, trmt2, clr2, busy2, err2;
    logic [8:0]  ram_addr2;
    logic [7:0]  tx_data2;

    int n_cmp = 0;
    int n_fail = 0;

    logic [8:0] addr_q[$];
    logic [7:0] data_q[$];
    int clr_cnt1 = 0;
    int err_cnt1 = 0;

    always #5 clk = ~clk;

    assign tx_done1 = auto_tx | man_tx;

    trace_dump #(.DEPTH(512), .ADDR_W(9), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .dump_req(dump_req1), .dump_ch(dump_ch1),
        .dump_abort(dump_abort1), .capture_done(capture_done), .trace_end(trace_end1),
        .rdata(rdata1), .tx_done(tx_done1), .ram_en(ram_en1), .ram_addr(ram_addr1),
        .tx_data(tx_data1), .trmt(trmt1), .clr_capture_done(clr1),
        .dump_busy(busy1), .dump_err(err1)
    );

    trace_dump #(.DEPTH(512), .ADDR_W(9), .DATA_W(8), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .dump_req(dump_req2), .dump_ch(dump_ch2),
        .dump_abort(dump_abort2), .capture_done(capture_done), .trace_end(trace_end2),
        .rdata(rdata2), .tx_done(tx_done2), .ram_en(ram_en2), .ram_addr(ram_addr2),
        .tx_data(tx_data2), .trmt(trmt2), .clr_capture_done(clr2),
        .dump_busy(busy2), .dump_err(err2)
    );

    // RAM contents: a distinct pattern per channel so a wrong channel shows up.
    function automatic logic [7:0] exp_byte(input int c, input int a);
        logic [7:0] lo;
        lo = a[7:0];
        case (c)
            0:       return ~lo;
            1:       return lo + 8'h11;
            2:       return lo;
            default: return lo ^ 8'hA5;
        endcase
    endfunction

    function automatic logic [31:0] ram_word(input int a);
        return {exp_byte(3, a), exp_byte(2, a), exp_byte(1, a), exp_byte(0, a)};
    endfunction

    // Synchronous RAM models: 1-cycle and 2-cycle read latency.
    always @(posedge clk) begin
        if (ram_en1) rdata1 <= ram_word(int'(ram_addr1));
        if (ram_en2) pipe2 <= ram_word(int'(ram_addr2));
        rdata2 <= pipe2;
    end

    // Transaction log of instance 1.
    initial begin
        forever begin
            @(negedge clk);
            if (ram_en1) addr_q.push_back(ram_addr1);
            if (trmt1)   data_q.push_back(tx_data1);
            if (clr1)    clr_cnt1++;
            if (err1)    err_cnt1++;
        end
    end

    // UART stand-in: tx_done two cycles after each trmt.
    initial begin
        auto_tx = 1'b0;
        forever begin
            @(negedge clk);
            if (trmt1 && auto_en) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                auto_tx = 1'b1;
                @(posedge clk); #1;
                auto_tx = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req_v);
        n_cmp++;
        assert (obs === req_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, req_v);
        end
    endtask

    task automatic chk_idle1(input string tag);
        chk({tag, "_ram_en"}, 32'(ram_en1), 0);
        chk({tag, "_ram_addr"}, 32'(ram_addr1), 0);
        chk({tag, "_tx_data"}, 32'(tx_data1), 0);
        chk({tag, "_trmt"}, 32'(trmt1), 0);
        chk({tag, "_clr"}, 32'(clr1), 0);
        chk({tag, "_busy"}, 32'(busy1), 0);
        chk({tag, "_err"}, 32'(err1), 0);
    endtask

    task automatic start1(input logic [8:0] te, input logic [1:0] ch);
        trace_end1 = te;
        dump_ch1   = ch;
        dump_req1  = 1'b1;
        cyc();
        dump_req1  = 1'b0;
    endtask

    // Waits for the end-of-dump pulse, then checks order and content of all 512 bytes.
    task automatic full_dump1(input string tag, input logic [8:0] te, input logic [1:0] ch);
        int ab, db, cb, n, bad, a;
        ab = addr_q.size();
        db = data_q.size();
        cb = clr_cnt1;
        start1(te, ch);
        chk({tag, "_busy_hi"}, 32'(busy1), 1);
        n = 0;
        while (clr_cnt1 == cb && n < 4000) begin
            cyc();
            n++;
        end
        chk({tag, "_clr_once"}, 32'(clr_cnt1 - cb), 1);
        chk({tag, "_busy_lo"}, 32'(busy1), 0);
        chk({tag, "_n_addr"}, 32'(addr_q.size() - ab), 512);
        chk({tag, "_n_bytes"}, 32'(data_q.size() - db), 512);
        bad = 512;
        if (addr_q.size() - ab >= 512 && data_q.size() - db >= 512) begin
            bad = 0;
            for (int i = 0; i < 512; i++) begin
                a = (int'(te) + 1 + i) % 512;
                if (addr_q[ab+i] !== 9'(a) || data_q[db+i] !== exp_byte(int'(ch), a)) bad++;
            end
            chk({tag, "_first_addr"}, 32'(addr_q[ab]), 32'((int'(te) + 1) % 512));
            chk({tag, "_last_addr"}, 32'(addr_q[ab+511]), 32'(te));
        end
        chk({tag, "_seq_errors"}, 32'(bad), 0);
    endtask

    initial begin
        int db, cb, ab, eb, n;
        rst = 1'b1; capture_done = 1'b0; auto_en = 1'b0; man_tx = 1'b0;
        dump_req1 = 1'b0; dump_abort1 = 1'b0; dump_ch1 = 2'd0; trace_end1 = 9'd0;
        dump_req2 = 1'b0; dump_abort2 = 1'b0; dump_ch2 = 2'd0; trace_end2 = 9'd0;
        tx_done2 = 1'b0;
        repeat (3) cyc();
        rst = 1'b0;
        chk_idle1("reset");

        // Request without a valid capture: one-cycle error, nothing else.
        ab = addr_q.size(); db = data_q.size(); cb = clr_cnt1; eb = err_cnt1;
        dump_req1 = 1'b1;
        cyc();
        dump_req1 = 1'b0;
        chk("err_pulse", 32'(err1), 1);
        chk("err_busy", 32'(busy1), 0);
        cyc();
        chk("err_drop", 32'(err1), 0);
        repeat (5) cyc();
        chk("err_count", 32'(err_cnt1 - eb), 1);
        chk("err_no_ram", 32'(addr_q.size() - ab), 0);
        chk("err_no_trmt", 32'(data_q.size() - db), 0);
        chk("err_no_clr", 32'(clr_cnt1 - cb), 0);

        // Two-cycle read latency, channel 3, channel change mid-dump.
        capture_done = 1'b1;
        trace_end2 = 9'h1FF;
        dump_ch2   = 2'd3;
        dump_req2  = 1'b1;
        cyc();
        dump_req2  = 1'b0;
        chk("lat2_ram_en", 32'(ram_en2), 1);
        chk("lat2_ram_addr", 32'(ram_addr2), 0);
        dump_ch2 = 2'd0;
        cyc();
        chk("lat2_w1_trmt", 32'(trmt2), 0);
        chk("lat2_w1_data", 32'(tx_data2), 0);
        cyc();
        chk("lat2_w2_trmt", 32'(trmt2), 0);
        cyc();
        chk("lat2_data", 32'(tx_data2), 32'hA5);
        chk("lat2_trmt", 32'(trmt2), 1);
        cyc();
        chk("lat2_txw_trmt", 32'(trmt2), 0);
        chk("lat2_hold", 32'(tx_data2), 32'hA5);
        tx_done2 = 1'b1;
        cyc();
        tx_done2 = 1'b0;
        chk("lat2_addr1", 32'(ram_addr2), 1);
        repeat (3) cyc();
        chk("lat2_ch_kept", 32'(tx_data2), 32'hA4);
        dump_abort2 = 1'b1;
        #1;
        chk("lat2_abort_trmt", 32'(trmt2), 0);
        cyc();
        dump_abort2 = 1'b0;
        chk("lat2_abort_clr", 32'(clr2), 1);
        cyc();
        chk("lat2_busy_lo", 32'(busy2), 0);

        // Full dump from trace_end=0x1FF on channel 2, then a wrapping dump.
        auto_en = 1'b1;
        full_dump1("dump_1ff", 9'h1FF, 2'd2);
        cyc();
        full_dump1("dump_005", 9'h005, 2'd1);
        cyc();

        // Abort together with tx_done after the tenth byte.
        auto_en = 1'b0;
        db = data_q.size(); cb = clr_cnt1;
        start1(9'h0FF, 2'd0);
        for (int b = 1; b <= 10; b++) begin
            n = 0;
            while (trmt1 !== 1'b1 && n < 20) begin
                cyc();
                n++;
            end
            chk("abort_trmt_seen", 32'(trmt1), 1);
            cyc();
            man_tx = 1'b1;
            if (b == 10) dump_abort1 = 1'b1;
            cyc();
            man_tx = 1'b0;
            dump_abort1 = 1'b0;
        end
        chk("abort_clr", 32'(clr1), 1);
        chk("abort_no_trmt", 32'(trmt1), 0);
        cyc();
        chk("abort_idle", 32'(busy1), 0);
        repeat (10) cyc();
        chk("abort_bytes", 32'(data_q.size() - db), 10);
        chk("abort_clr_once", 32'(clr_cnt1 - cb), 1);
        if (data_q.size() - db >= 10) chk("abort_byte10", 32'(data_q[db+9]), 32'hF6);
        start1(9'h0FF, 2'd0);
        chk("restart_ram_en", 32'(ram_en1), 1);
        chk("restart_addr", 32'(ram_addr1), 32'h100);
        dump_abort1 = 1'b1;
        cyc();
        dump_abort1 = 1'b0;
        chk("rd_abort_clr", 32'(clr1), 1);
        cyc();

        // Reset in the middle of a dump after 100 bytes.
        auto_en = 1'b1;
        db = data_q.size();
        start1(9'h1FF, 2'd2);
        n = 0;
        while (data_q.size() - db < 100 && n < 2000) begin
            cyc();
            n++;
        end
        chk("rst_reached_100", 32'(data_q.size() - db >= 100), 1);
        cb = clr_cnt1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk_idle1("mid_rst");
        repeat (6) cyc();
        chk("mid_rst_no_clr", 32'(clr_cnt1 - cb), 0);
        full_dump1("after_rst", 9'h1FF, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/trace_dump.md
Name: trace_dump

Overview:
- Readout stage directly downstream of the capture engine.
- Once a capture completes, it unrolls the 512-entry circular sample RAM for one selected channel, from oldest to newest sample.
- Each sample is handed byte-by-byte to the UART transmitter through a trmt/tx_done handshake.
- When the dump finishes it pulses clr_capture_done, which re-enables capture.

Parameters:
- DEPTH, 512, number of entries in each channel RAM; must be a power of 2.
- ADDR_W, 9, RAM address width; equals log2(DEPTH).
- DATA_W, 8, sample width.
- RD_LAT, 1, RAM read latency in clk cycles from ram_en to valid rdata; legal range 1..3.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- dump_req  input  1  single-cycle pulse that requests a dump.
- dump_ch  input  2  channel to dump; sampled only when dump_req is accepted.
- dump_abort  input  1  single-cycle pulse that terminates a dump in progress.
- capture_done  input  1  a capture is complete and the RAM holds a valid trace.
- trace_end  input  ADDR_W  address of the newest written sample.
- rdata  input  4*DATA_W  read data from the four channel RAMs, channel n at bits [n*DATA_W +: DATA_W].
- tx_done  input  1  pulse from the UART when the current byte has been sent.
- ram_en  output  1  RAM read enable.
- ram_addr  output  ADDR_W  RAM read address.
- tx_data  output  DATA_W  byte to transmit.
- trmt  output  1  single-cycle pulse that starts a UART transmit.
- clr_capture_done  output  1  single-cycle pulse at the end of a dump, normal or aborted.
- dump_busy  output  1  high from the accepted request until the return to IDLE.
- dump_err  output  1  single-cycle pulse when dump_req arrives while capture_done is low.

Behaviour:
- Reset: state IDLE. All outputs are 0 (ram_addr=0, tx_data=0). Internal sample count=0, latched channel=0. Reset mid-dump discards the dump without pulsing clr_capture_done.
- States and transitions:
  - IDLE → RD when dump_req & capture_done. On entry: latch dump_ch into ch_q, set rd_ptr=(trace_end+1) mod DEPTH, set cnt=0, dump_busy=1.
  - In IDLE, dump_req & ~capture_done → pulse dump_err for 1 cycle; remain in IDLE.
  - RD: drive ram_en=1 and ram_addr=rd_ptr for exactly 1 cycle → RDW.
  - RDW: wait RD_LAT cycles. Capture rdata[ch_q] into tx_data on the cycle data is valid → SEND.
  - SEND: pulse trmt for 1 cycle → TXW.
  - TXW: wait for tx_done. On tx_done: increment cnt and rd_ptr, with rd_ptr wrapping DEPTH-1→0.
    - If cnt was DEPTH-1 (last sample) → FIN.
    - Otherwise → RD.
  - FIN: pulse clr_capture_done for 1 cycle, drop dump_busy → IDLE.
- Ordering: exactly DEPTH bytes are sent. The first is at address trace_end+1 and the last at trace_end.
- Arithmetic: rd_ptr is ADDR_W bits and wraps naturally. cnt is ADDR_W+1 bits so it can hold the value DEPTH.
- tx_data holds its value through TXW. trmt never pulses again until tx_done has been seen.
- dump_abort in any non-IDLE state:
  - go to FIN next cycle, suppressing any pending trmt;
  - clr_capture_done still pulses.
- dump_abort in IDLE is ignored.
- Simultaneous events: tx_done and dump_abort in the same cycle → abort wins; cnt is not incremented.
- dump_req while busy is ignored. dump_ch changes while busy have no effect.
- A tx_done arriving outside TXW is ignored.
- Throughput: with immediate tx_done, one byte takes RD_LAT+3 cycles (RD, RD_LAT waits, SEND, TXW).

Test Plan:
- trace_end=0x1FF, dump_ch=2, RAM ch2[i]=i[7:0], tx_done returned 2 cycles after each trmt → 512 trmt pulses, with ram_addr 0x000..0x1FF in order and tx_data=0x00..0xFF twice; single clr_capture_done after the 512th tx_done; dump_busy then falls.
- trace_end=0x005 → first ram_addr=0x006; address wraps 0x1FF→0x000; the last byte is read from 0x005; the total byte count is exactly 512.
- dump_req with capture_done=0 → one-cycle dump_err; no ram_en, trmt or clr_capture_done; dump_busy stays 0.
- dump_abort asserted in TXW after byte 10, together with tx_done → no 11th trmt; clr_capture_done pulses the next cycle; returns to IDLE; a new dump_req restarts from trace_end+1.
- RD_LAT=2, ch3 data 0xA5 at address trace_end+1 → tx_data=0xA5 is captured two cycles after ram_en and trmt follows; a dump_ch change mid-dump has no effect on tx_data.
- rst asserted mid-dump at byte 100 → all outputs are 0 on the next clock; no clr_capture_done pulse; a subsequent dump starts cleanly.
